// File: rtl/mem_pkg.sv
// Shared definitions for the unified memory responder: load/store size codes,
// MMIO register offsets and the address decode result.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] OFF_LED   = 4'h0;
  localparam logic [3:0] OFF_CYCLE = 4'h4;

  typedef enum logic [1:0] {HIT_RAM, HIT_MMIO, HIT_NONE} hit_e;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  function automatic logic f3_valid(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Fetches are always full words; data accesses are sized by Funct3[1:0].
  function automatic size_e access_size(input logic data_access, input logic [2:0] f3);
    if (!data_access) return SzWord;
    case (f3[1:0])
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering shared by the RAM and MMIO paths: store byte enables with
// replicated data, and load lane selection with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata     = rword;
    shifted   = rword >> {lane, 3'b000};
    case (size)
      SzByte: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      SzHalf: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
      end
    endcase
  end

endmodule

// File: rtl/memory_responder.sv
// Unified instruction/data memory for the multicycle core: byte-lane RAM, LED and
// cycle-counter MMIO window, and sticky capture of the first faulting access.
module memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        DataAccess,
  input  logic [2:0]  Funct3,
  output logic [31:0] ReadData,
  output logic [7:0]  Leds,
  output logic        Fault,
  output logic [31:0] FaultAdr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  hit_e        hit;
  size_e       size;
  logic        misalign;
  logic        fault_now;
  logic [3:0]  mmio_off;
  logic [31:0] rword;
  logic [31:0] rdata_al;
  logic [31:0] wdata_rep;
  logic [3:0]  be;
  logic        store;
  logic        ram_we;
  logic        led_we;

  logic [7:0]  led_q, led_d;
  logic [31:0] cycle_q, cycle_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_adr_q, fault_adr_d;

  assign size     = access_size(DataAccess, Funct3);
  assign mmio_off = {Adr[3:2], 2'b00};

  always_comb begin
    if (Adr[31:AW+2] == '0) begin
      hit = HIT_RAM;
    end else if (Adr[31:4] == MMIO_BASE[31:4]) begin
      hit = HIT_MMIO;
    end else begin
      hit = HIT_NONE;
    end
  end

  always_comb begin
    misalign  = ((size == SzHalf) && Adr[0]) || ((size == SzWord) && (Adr[1:0] != 2'b00));
    fault_now = misalign || (hit == HIT_NONE) || (DataAccess && !f3_valid(Funct3)) ||
                (MemWrite && !DataAccess);
  end

  always_comb begin
    rword = '0;
    case (hit)
      HIT_RAM:  rword = mem[Adr[AW+1:2]];
      HIT_MMIO: begin
        if (mmio_off == OFF_LED) begin
          rword = {24'h0, led_q};
        end else if (mmio_off == OFF_CYCLE) begin
          rword = cycle_q;
        end
      end
      default:  rword = '0;
    endcase
  end

  mem_lane_align u_lane_align (
    .size      (size),
    .sext      (~Funct3[2]),
    .lane      (Adr[1:0]),
    .wdata     (WriteData),
    .rword     (rword),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata     (rdata_al)
  );

  assign ReadData = fault_now ? 32'h0 : rdata_al;

  // Stores are dropped on any fault and during the reset cycle.
  assign store  = rst_n && MemWrite && DataAccess && !fault_now;
  assign ram_we = store && (hit == HIT_RAM);
  assign led_we = store && (hit == HIT_MMIO) && (mmio_off == OFF_LED) && (size != SzHalf) &&
                  be[0];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && be[i]) begin
        mem[Adr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_comb begin
    led_d       = led_q;
    cycle_d     = cycle_q + 32'd1;
    fault_d     = fault_q;
    fault_adr_d = fault_adr_q;
    if (led_we) begin
      led_d = wdata_rep[7:0];
    end
    if (fault_now) begin
      fault_d = 1'b1;
      if (!fault_q) begin
        fault_adr_d = Adr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q       <= '0;
      cycle_q     <= '0;
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
    end else begin
      led_q       <= led_d;
      cycle_q     <= cycle_d;
      fault_q     <= fault_d;
      fault_adr_q <= fault_adr_d;
    end
  end

  assign Leds     = led_q;
  assign Fault    = fault_q;
  assign FaultAdr = fault_adr_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: table-driven load/store/MMIO vectors, a fault
// vector table, and hand sequences for reset, cycle counter and first-fault capture.
module tb_memory_responder;

  logic        clk;
  logic        rst_n;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        DataAccess;
  logic [2:0]  Funct3;
  logic [31:0] ReadData;
  logic [7:0]  Leds;
  logic        Fault;
  logic [31:0] FaultAdr;

  int checks   = 0;
  int failures = 0;

  memory_responder #(
    .DEPTH_WORDS (1024),
    .INIT_FILE   (""),
    .MMIO_BASE   (32'hFFFF_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Adr        (Adr),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .DataAccess (DataAccess),
    .Funct3     (Funct3),
    .ReadData   (ReadData),
    .Leds       (Leds),
    .Fault      (Fault),
    .FaultAdr   (FaultAdr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic        da;
    logic [2:0]  f3;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_leds;
  } vec_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] wd;
    logic        we;
    logic        da;
    logic [2:0]  f3;
  } fvec_t;

  vec_t  vecs[24];
  fvec_t fvecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] adr, input logic [31:0] wd, input logic we,
                       input logic da, input logic [2:0] f3);
    Adr        = adr;
    WriteData  = wd;
    MemWrite   = we;
    DataAccess = da;
    Funct3     = f3;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 3'b010);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 3'b010);

    vecs[0]  = '{32'h10, 32'h8000_80FF, 1, 1, 3'b010, 0, 32'h0, 8'h00};
    vecs[1]  = '{32'h10, 32'h0, 0, 1, 3'b000, 1, 32'hFFFF_FFFF, 8'h00};
    vecs[2]  = '{32'h10, 32'h0, 0, 1, 3'b100, 1, 32'h0000_00FF, 8'h00};
    vecs[3]  = '{32'h12, 32'h0, 0, 1, 3'b001, 1, 32'hFFFF_8000, 8'h00};
    vecs[4]  = '{32'h12, 32'h0, 0, 1, 3'b101, 1, 32'h0000_8000, 8'h00};
    vecs[5]  = '{32'h10, 32'h0, 0, 1, 3'b010, 1, 32'h8000_80FF, 8'h00};
    vecs[6]  = '{32'h11, 32'h0, 0, 1, 3'b000, 1, 32'hFFFF_FF80, 8'h00};
    vecs[7]  = '{32'h13, 32'h0, 0, 1, 3'b100, 1, 32'h0000_0080, 8'h00};
    vecs[8]  = '{32'h20, 32'h1122_3344, 1, 1, 3'b010, 0, 32'h0, 8'h00};
    vecs[9]  = '{32'h20, 32'h0, 0, 1, 3'b010, 1, 32'h1122_3344, 8'h00};
    vecs[10] = '{32'h21, 32'hFFFF_FFAB, 1, 1, 3'b000, 1, 32'h0000_0033, 8'h00};
    vecs[11] = '{32'h20, 32'h0, 0, 1, 3'b010, 1, 32'h1122_AB44, 8'h00};
    vecs[12] = '{32'h22, 32'h0000_BEEF, 1, 1, 3'b001, 1, 32'h0000_1122, 8'h00};
    vecs[13] = '{32'h20, 32'h0, 0, 1, 3'b010, 1, 32'hBEEF_AB44, 8'h00};
    vecs[14] = '{32'h20, 32'h0, 0, 1, 3'b101, 1, 32'h0000_AB44, 8'h00};
    vecs[15] = '{32'h22, 32'h0, 0, 1, 3'b001, 1, 32'hFFFF_BEEF, 8'h00};
    vecs[16] = '{32'h20, 32'h0, 0, 0, 3'b111, 1, 32'hBEEF_AB44, 8'h00};
    vecs[17] = '{32'hFFFF_0000, 32'h1234_56A5, 1, 1, 3'b010, 1, 32'h0, 8'hA5};
    vecs[18] = '{32'hFFFF_0000, 32'h0, 0, 1, 3'b010, 1, 32'h0000_00A5, 8'hA5};
    vecs[19] = '{32'hFFFF_0001, 32'h0, 0, 1, 3'b100, 1, 32'h0, 8'hA5};
    vecs[20] = '{32'hFFFF_0000, 32'h0000_005A, 1, 1, 3'b000, 1, 32'hFFFF_FFA5, 8'h5A};
    vecs[21] = '{32'hFFFF_0000, 32'h0000_0077, 1, 1, 3'b001, 1, 32'h0000_005A, 8'h5A};
    vecs[22] = '{32'hFFFF_0008, 32'h0, 0, 1, 3'b010, 1, 32'h0, 8'h5A};
    vecs[23] = '{32'hFFFF_000F, 32'h0, 0, 1, 3'b000, 1, 32'h0, 8'h5A};

    fvecs[0]  = '{32'h11, 32'h0, 0, 1, 3'b001};
    fvecs[1]  = '{32'h13, 32'h0, 0, 1, 3'b101};
    fvecs[2]  = '{32'h12, 32'h0, 0, 1, 3'b010};
    fvecs[3]  = '{32'h8000, 32'h0, 0, 1, 3'b010};
    fvecs[4]  = '{32'h4000, 32'h0, 0, 1, 3'b000};
    fvecs[5]  = '{32'hFFFE_0000, 32'h0, 0, 0, 3'b010};
    fvecs[6]  = '{32'h0, 32'h0, 0, 1, 3'b011};
    fvecs[7]  = '{32'h4, 32'h0, 0, 1, 3'b110};
    fvecs[8]  = '{32'h8, 32'h0, 0, 1, 3'b111};
    fvecs[9]  = '{32'h8, 32'h5555_5555, 1, 0, 3'b010};
    fvecs[10] = '{32'hFFFF_0002, 32'h0, 1, 1, 3'b010};
    fvecs[11] = '{32'h21, 32'h0, 1, 1, 3'b001};

    // Cycle counter: one reset edge, then five counting edges.
    do_reset();
    chk("reset_leds", {24'h0, Leds}, 32'h0);
    chk("reset_fault", {31'h0, Fault}, 32'h0);
    chk("reset_fault_adr", FaultAdr, 32'h0);
    repeat (5) tick();
    drive(32'hFFFF_0004, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b010);
    #1 chk("cycle_after_5", ReadData, 32'd5);
    tick();
    chk("cycle_write_no_fault", {31'h0, Fault}, 32'h0);
    drive(32'hFFFF_0004, 32'h0, 1'b0, 1'b1, 3'b010);
    #1 chk("cycle_write_ignored", ReadData, 32'd6);
    dut.cycle_q = 32'hFFFF_FFFE;
    #1 chk("cycle_forced", ReadData, 32'hFFFF_FFFE);
    tick();
    chk("cycle_max", ReadData, 32'hFFFF_FFFF);
    tick();
    chk("cycle_wrap", ReadData, 32'h0);

    // First fault wins.
    do_reset();
    drive(32'h2, 32'h0, 1'b0, 1'b0, 3'b010);
    #1 chk("unaligned_fetch_rd", ReadData, 32'h0);
    tick();
    chk("unaligned_fetch_fault", {31'h0, Fault}, 32'h1);
    chk("unaligned_fetch_adr", FaultAdr, 32'h2);
    drive(32'h6, 32'h0, 1'b0, 1'b0, 3'b010);
    tick();
    chk("second_fault_sticky", {31'h0, Fault}, 32'h1);
    chk("second_fault_adr_kept", FaultAdr, 32'h2);

    // Load/store and MMIO vectors.
    do_reset();
    chk("reset_clears_fault", {31'h0, Fault}, 32'h0);
    chk("reset_clears_fault_adr", FaultAdr, 32'h0);
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].adr, vecs[i].wd, vecs[i].we, vecs[i].da, vecs[i].f3);
      #1;
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), ReadData, vecs[i].exp_rd);
      tick();
      chk($sformatf("vec%0d_fault", i), {31'h0, Fault}, 32'h0);
      chk($sformatf("vec%0d_leds", i), {24'h0, Leds}, {24'h0, vecs[i].exp_leds});
    end

    // Unmapped store aliasing word 0 must not reach RAM; reset-cycle store is dropped.
    drive(32'h0, 32'hCAFE_F00D, 1'b1, 1'b1, 3'b010);
    tick();
    drive(32'h8000, 32'h0BAD_BEEF, 1'b1, 1'b1, 3'b010);
    #1 chk("unmapped_sw_rd", ReadData, 32'h0);
    tick();
    chk("unmapped_sw_fault", {31'h0, Fault}, 32'h1);
    chk("unmapped_sw_adr", FaultAdr, 32'h8000);
    drive(32'h0, 32'h0, 1'b0, 1'b1, 3'b010);
    #1 chk("unmapped_sw_ram_kept", ReadData, 32'hCAFE_F00D);
    rst_n = 1'b0;
    drive(32'h0, 32'h1234_5678, 1'b1, 1'b1, 3'b010);
    tick();
    rst_n = 1'b1;
    chk("rst_store_fault_clr", {31'h0, Fault}, 32'h0);
    chk("rst_store_fault_adr", FaultAdr, 32'h0);
    chk("rst_store_leds", {24'h0, Leds}, 32'h0);
    drive(32'h0, 32'h0, 1'b0, 1'b1, 3'b010);
    #1 chk("rst_store_suppressed", ReadData, 32'hCAFE_F00D);

    // Fault conditions, each from a clean reset.
    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(fvecs[i].adr, fvecs[i].wd, fvecs[i].we, fvecs[i].da, fvecs[i].f3);
      #1 chk($sformatf("fvec%0d_rd", i), ReadData, 32'h0);
      tick();
      chk($sformatf("fvec%0d_fault", i), {31'h0, Fault}, 32'h1);
      chk($sformatf("fvec%0d_adr", i), FaultAdr, fvecs[i].adr);
    end

    // The suppressed fetch-write at 0x8 and misaligned sh at 0x21 left RAM alone.
    do_reset();
    drive(32'h20, 32'h0, 1'b0, 1'b1, 3'b010);
    #1 chk("misaligned_sh_ram_kept", ReadData, 32'hBEEF_AB44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
